// File: rtl/ram32_master_pkg.sv
// Shared definitions for the RAM32 command master.
// Contents: opcode and state enumerations, default widths, burst length cap.
// Optional feature macro used by ram32_master: RAM32_MASTER_CHECKSUM_EN.
package ram32_master_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned MAX_LEN    = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_FILL  = 2'b10,
    OP_COPY  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP,
    S_FILL,
    S_CP_RD,
    S_CP_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/ram32_addr_counter.sv
// Wrapping address counter with synchronous load and increment.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over inc)
//   inc        : advance by one, wrapping at 2**ADDR_W
//   load_val   : value to load
//   q          : current count
//   nxt        : q + 1 (wrapped), for callers that need the look-ahead value
module ram32_addr_counter
  import ram32_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] q,
  output logic [ADDR_W-1:0] nxt
);

  assign nxt = q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= load_val;
    else if (inc)  q <= nxt;
  end

endmodule

// File: rtl/ram32_master.sv
// Command-driven initiator for the RAM32 array: single WRITE / READ and
// burst FILL / COPY, one command at a time over a valid/ready handshake,
// READ data returned on a valid/ready response channel.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_op/addr/addr2/len/data : command fields, captured on acceptance
//   rsp_valid/rsp_ready/rsp_data : READ response channel
//   done, busy                 : completion pulse, not-idle flag
//   mem_addr/mem_wdata/mem_write/mem_rdata : RAM side (rdata combinational)
// Optional: define RAM32_MASTER_CHECKSUM_EN to add output wsum, the wrapping
// sum of every word written since the last command acceptance.
module ram32_master
  import ram32_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef RAM32_MASTER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] wsum
`endif
);

  localparam logic [ADDR_W:0] LEN_CAP = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W:0]   eff_len;
  logic              accept;
  logic [ADDR_W-1:0] src_q, src_nxt, dst_q, dst_nxt_unused;

  assign accept  = cmd_valid && (state == S_IDLE);
  assign eff_len = (cmd_len > LEN_CAP) ? LEN_CAP : cmd_len;

  // The source counter advances as soon as a word has been read (CP_RD), so
  // its plain value is the next source address when CP_WR schedules the
  // following read; FILL uses the look-ahead output instead.
  ram32_addr_counter #(.ADDR_W(ADDR_W)) u_src (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .inc      ((state == S_FILL) || (state == S_CP_RD)),
    .load_val (cmd_addr),
    .q        (src_q),
    .nxt      (src_nxt)
  );

  ram32_addr_counter #(.ADDR_W(ADDR_W)) u_dst (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .inc      (state == S_CP_WR),
    .load_val (cmd_addr2),
    .q        (dst_q),
    .nxt      (dst_nxt_unused)
  );

  // mem_wdata doubles as the COPY hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      remain    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            mem_addr  <= cmd_addr;
            mem_wdata <= cmd_data;
            remain    <= eff_len;
            case (op_t'(cmd_op))
              OP_WRITE: begin
                mem_write <= 1'b1;
                state     <= S_WR;
              end
              OP_READ: state <= S_RD;
              OP_FILL: begin
                if (eff_len == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  mem_write <= 1'b1;
                  state     <= S_FILL;
                end
              end
              default: begin
                if (eff_len == '0) begin
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  state <= S_CP_RD;
                end
              end
            endcase
          end
        end
        S_WR: begin
          mem_write <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_RD: begin
          rsp_data  <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_FILL: begin
          if (remain == LEN_ONE) begin
            mem_write <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            mem_addr <= src_nxt;
            remain   <= remain - LEN_ONE;
          end
        end
        S_CP_RD: begin
          mem_wdata <= mem_rdata;
          mem_addr  <= dst_q;
          mem_write <= 1'b1;
          state     <= S_CP_WR;
        end
        S_CP_WR: begin
          mem_write <= 1'b0;
          if (remain == LEN_ONE) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            mem_addr <= src_q;
            remain   <= remain - LEN_ONE;
            state    <= S_CP_RD;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef RAM32_MASTER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         wsum <= '0;
    else if (accept)    wsum <= '0;
    else if (mem_write) wsum <= wsum + mem_wdata;
  end
`endif

endmodule

// File: tb/tb_ram32_master.sv
// Self-checking bench for ram32_master: directed vector table, reset-abort
// sequence and randomized commands checked against a word-level model.
module tb_ram32_master;
  import ram32_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_addr = '0, cmd_addr2 = '0;
  logic [5:0]  cmd_len = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        done, busy;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic [15:0] mem_rdata;
`ifdef RAM32_MASTER_CHECKSUM_EN
  logic [15:0] wsum;
`endif

  ram32_master #(.ADDR_W(5), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_addr2(cmd_addr2), .cmd_len(cmd_len),
    .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
`ifdef RAM32_MASTER_CHECKSUM_EN
    , .wsum(wsum)
`endif
  );

  always #5 clk = ~clk;

  // RAM array model and the bench's own reference copy of its contents.
  logic [15:0] ram [32];
  logic [15:0] ref_mem [32];
  assign mem_rdata = ram[mem_addr];

  initial begin
    for (int i = 0; i < 32; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end
    forever begin
      @(posedge clk);
      if (mem_write) ram[mem_addr] = mem_wdata;
    end
  end

  typedef struct packed {
    logic [4:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t wq[$];
  wr_t exp_wq[$];

  always @(negedge clk) if (mem_write) wq.push_back({mem_addr, mem_wdata});

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  a;
    logic [4:0]  a2;
    logic [5:0]  len;
    logic [15:0] d;
    int          hold;
    int          exp_lat;
    logic        chk_rsp;
    logic [15:0] exp_rsp;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [4:0] a, input logic [4:0] a2,
                              input logic [5:0] len, input logic [15:0] d, input int hold,
                              input int lat, input logic cr, input logic [15:0] rsp);
    vec_t v;
    v.op = op; v.a = a; v.a2 = a2; v.len = len; v.d = d; v.hold = hold;
    v.exp_lat = lat; v.chk_rsp = cr; v.exp_rsp = rsp;
    return v;
  endfunction

  logic [15:0] m_sum;

  task automatic m_write(input logic [4:0] a, input logic [15:0] d);
    exp_wq.push_back({a, d});
    ref_mem[a] = d;
    m_sum = m_sum + d;
  endtask

  // Word-level reference: expected write list, memory effect, latency, READ data.
  task automatic model(input vec_t v, output int lat, output logic [15:0] rsp);
    int n;
    n = (v.len > 32) ? 32 : int'(v.len);
    exp_wq.delete();
    m_sum = '0;
    rsp = '0;
    case (v.op)
      2'b00: begin m_write(v.a, v.d); lat = 2; end
      2'b01: begin rsp = ref_mem[v.a]; lat = 3 + v.hold; end
      2'b10: begin
        for (int i = 0; i < n; i++) m_write(5'((int'(v.a) + i) % 32), v.d);
        lat = n + 1;
      end
      default: begin
        for (int i = 0; i < n; i++)
          m_write(5'((int'(v.a2) + i) % 32), ref_mem[5'((int'(v.a) + i) % 32)]);
        lat = 2 * n + 1;
      end
    endcase
  endtask

  // Called on a negedge; returns on the negedge where done is observed.
  task automatic run(input vec_t v, input string tag);
    int lat_m, k, rc;
    logic [15:0] rsp_m, held;
    model(v, lat_m, rsp_m);
    cmd_valid = 1'b1;
    cmd_op = v.op; cmd_addr = v.a; cmd_addr2 = v.a2; cmd_len = v.len; cmd_data = v.d;
    k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
      if (cmd_ready) chk({tag, "_done_1cyc"}, 64'(done), 64'(0));
    end
    if (!cmd_ready) begin
      chk({tag, "_accept_timeout"}, 64'(0), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    wq.delete();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_addr = 5'($urandom); cmd_addr2 = 5'($urandom);
    cmd_len = 6'($urandom); cmd_data = 16'($urandom);
    k = 0; rc = 0; held = '0;
    while (k < 300) begin
      @(negedge clk);
      k++;
      if (rsp_valid) begin
        if (rc == 0) held = rsp_data;
        else begin
          chk({tag, "_rsp_stable"}, 64'(rsp_data), 64'(held));
          chk({tag, "_ready_low_in_rsp"}, 64'(cmd_ready), 64'(0));
        end
        if (rc == v.hold) rsp_ready = 1'b1;
        rc++;
      end
      if (done) break;
    end
    rsp_ready = 1'b0;
    if (!done) begin
      chk({tag, "_done_timeout"}, 64'(0), 64'(1));
      return;
    end
    chk({tag, "_latency"}, 64'(k), 64'((v.exp_lat >= 0) ? v.exp_lat : lat_m));
    chk({tag, "_busy_at_done"}, 64'({cmd_ready, busy}), 64'(2'b01));
    if (v.op == 2'b01) begin
      chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(rsp_m));
      if (v.chk_rsp) chk({tag, "_rsp_table"}, 64'(rsp_data), 64'(v.exp_rsp));
    end
    chk({tag, "_nwrites"}, 64'(wq.size()), 64'(exp_wq.size()));
    for (int i = 0; i < wq.size() && i < exp_wq.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), 64'(wq[i]), 64'(exp_wq[i]));
`ifdef RAM32_MASTER_CHECKSUM_EN
    chk({tag, "_wsum"}, 64'(wsum), 64'(m_sum));
`endif
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {cmd_ready, rsp_valid, rsp_data, done, busy, mem_addr, mem_wdata, mem_write},
        {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 5'h0, 16'h0, 1'b0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  vec_t tbl[$];
  vec_t v;

  initial begin
    // WRITE/READ basics, held response, wrapping FILL, COPY, zero and oversize lengths.
    tbl.push_back(mk(2'b00, 5'd5,  5'd0,  6'd0,  16'hBEEF, 0, 2, 1'b0, 16'h0));
    tbl.push_back(mk(2'b01, 5'd5,  5'd0,  6'd9,  16'h0,    0, 3, 1'b1, 16'hBEEF));
    tbl.push_back(mk(2'b01, 5'd7,  5'd3,  6'd0,  16'h0,    4, 7, 1'b0, 16'h0));
    tbl.push_back(mk(2'b10, 5'd30, 5'd0,  6'd4,  16'h00A5, 0, 5, 1'b0, 16'h0));
    tbl.push_back(mk(2'b01, 5'd2,  5'd0,  6'd0,  16'h0,    0, 3, 1'b0, 16'h0));
    tbl.push_back(mk(2'b01, 5'd31, 5'd0,  6'd0,  16'h0,    1, 4, 1'b1, 16'h00A5));
    tbl.push_back(mk(2'b01, 5'd1,  5'd0,  6'd0,  16'h0,    0, 3, 1'b1, 16'h00A5));
    tbl.push_back(mk(2'b00, 5'd0,  5'd0,  6'd0,  16'h1111, 0, 2, 1'b0, 16'h0));
    tbl.push_back(mk(2'b00, 5'd1,  5'd0,  6'd0,  16'h2222, 0, 2, 1'b0, 16'h0));
    tbl.push_back(mk(2'b00, 5'd2,  5'd0,  6'd0,  16'h3333, 0, 2, 1'b0, 16'h0));
    tbl.push_back(mk(2'b11, 5'd0,  5'd16, 6'd3,  16'h0,    0, 7, 1'b0, 16'h0));
    tbl.push_back(mk(2'b01, 5'd16, 5'd0,  6'd0,  16'h0,    0, 3, 1'b1, 16'h1111));
    tbl.push_back(mk(2'b01, 5'd17, 5'd0,  6'd0,  16'h0,    0, 3, 1'b1, 16'h2222));
    tbl.push_back(mk(2'b01, 5'd18, 5'd0,  6'd0,  16'h0,    0, 3, 1'b1, 16'h3333));
    tbl.push_back(mk(2'b10, 5'd9,  5'd0,  6'd0,  16'hDEAD, 0, 1, 1'b0, 16'h0));
    tbl.push_back(mk(2'b11, 5'd3,  5'd4,  6'd0,  16'h0,    0, 1, 1'b0, 16'h0));
    tbl.push_back(mk(2'b10, 5'd20, 5'd0,  6'd40, 16'h1234, 0, 33, 1'b0, 16'h0));
    tbl.push_back(mk(2'b10, 5'd3,  5'd0,  6'd3,  16'h8000, 0, 4, 1'b0, 16'h0));
    tbl.push_back(mk(2'b00, 5'd9,  5'd0,  6'd0,  16'h0001, 0, 2, 1'b0, 16'h0));
    tbl.push_back(mk(2'b11, 5'd0,  5'd1,  6'd4,  16'h0,    0, 9, 1'b0, 16'h0));

    #12;
    chk_reset_vals("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

    // Abort a 32-word FILL after five written words.
    v = mk(2'b10, 5'd10, 5'd0, 6'd32, 16'h5A5A, 0, -1, 1'b0, 16'h0);
    cmd_valid = 1'b1;
    cmd_op = v.op; cmd_addr = v.a; cmd_addr2 = v.a2; cmd_len = v.len; cmd_data = v.d;
    while (!cmd_ready) @(negedge clk);
    wq.delete();
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_mem_write", 64'(mem_write), 64'(0));
    chk_reset_vals("abort_reset_state");
    for (int i = 0; i < 5; i++) ref_mem[5'(10 + i)] = 16'h5A5A;
    @(negedge clk);
    chk("abort_nwrites", 64'(wq.size()), 64'(5));
    rst_n = 1'b1;
    @(negedge clk);
    run(mk(2'b01, 5'd14, 5'd0, 6'd0, 16'h0, 0, 3, 1'b1, 16'h5A5A), "abort_rd_last");
    run(mk(2'b01, 5'd16, 5'd0, 6'd0, 16'h0, 0, 3, 1'b0, 16'h0), "abort_rd_beyond");

    for (int i = 0; i < 40; i++) begin
      v = mk(2'($urandom), 5'($urandom), 5'($urandom), 6'($urandom_range(0, 36)),
             16'($urandom), int'($urandom_range(0, 3)), -1, 1'b0, 16'h0);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram32_master.md
Name: ram32_master

Overview:
- Command-driven initiator for the RAM32 storage array. It drives the memory side (mem_addr, mem_wdata, mem_write) and samples mem_rdata.
- Accepts one command at a time over a valid/ready handshake. Commands are single WRITE, single READ, burst FILL, and burst COPY.
- Returns READ data over a valid/ready response channel.
- Sits between bus/CPU-side logic and the RAM32 array.

Parameters:
- ADDR_W, 5, memory address width (32 words).
- DATA_W, 16, memory word width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, able to accept a command.
- cmd_op  in  2  00 WRITE, 01 READ, 10 FILL, 11 COPY.
- cmd_addr  in  ADDR_W  target address (COPY: source).
- cmd_addr2  in  ADDR_W  COPY destination; ignored otherwise.
- cmd_len  in  ADDR_W+1  burst word count 0..32 (FILL/COPY only).
- cmd_data  in  DATA_W  write data / fill pattern.
- rsp_valid  out  1  READ data available.
- rsp_ready  in  1  consumer takes rsp_data.
- rsp_data  out  DATA_W  READ result.
- done  out  1  one-cycle pulse at command completion.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_write  out  1  RAM write enable.
- mem_rdata  in  DATA_W  RAM combinational read data.

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; done=0; busy=0; mem_addr=0; mem_wdata=0; mem_write=0. Any in-flight command is aborted and mem_write drops immediately.
- All outputs are registered. mem_addr, mem_wdata and mem_write change only on clk rising edges, so address and data are stable for the full cycle mem_write is high (the RAM cells are level-sensitive).
- Handshake: a command is accepted when cmd_valid && cmd_ready. cmd_ready = (state==IDLE). Command fields are captured on acceptance and may change afterwards.
- States: IDLE, WR, RD, RSP, FILL, CP_RD, CP_WR, DONE.
- WRITE:
  - IDLE→WR. WR holds mem_write=1 for exactly one cycle at cmd_addr.
  - WR→DONE. DONE pulses done=1, then →IDLE.
  - Latency from accept edge to done = 2 cycles.
- READ:
  - IDLE→RD. RD drives mem_addr=cmd_addr with mem_write=0; mem_rdata is captured into rsp_data at the end of RD.
  - RD→RSP. RSP holds rsp_valid=1 with rsp_data stable until rsp_ready.
  - RSP→DONE on the rsp_ready cycle; rsp_valid drops with the transition.
- FILL:
  - mem_write=1 for cmd_len consecutive cycles.
  - Address starts at cmd_addr and increments by 1 mod 32 each cycle (wraps 31→0). mem_wdata=cmd_data throughout.
  - Then →DONE.
- COPY:
  - Per word, CP_RD drives the src address and captures mem_rdata into a hold register; CP_WR writes the hold register to dst with mem_write=1.
  - src and dst each increment mod 32 after CP_WR. Cost is 2 cycles/word (2*cmd_len cycles), then →DONE.
  - Overlapping ranges: no special handling; words are copied strictly in ascending address order.
- cmd_len=0 for FILL/COPY: accepted, goes directly to DONE, mem_write never asserts.
- cmd_len>32: truncated to 32.
- cmd_len and cmd_addr2 are ignored for WRITE/READ.
- cmd_valid while busy: held off by cmd_ready=0 and not lost. The next command is accepted no earlier than the cycle after DONE.

Optional Feature:
- Macro: RAM32_MASTER_CHECKSUM_EN.
- Defined:
  - Adds output port wsum (DATA_W), a running 16-bit wrapping sum of every word written while mem_write=1 (WRITE, FILL, COPY).
  - Clears on reset and on acceptance of any command. It is valid and stable from the done pulse until the next acceptance.
- Undefined: no wsum port and no accumulator logic. All other behaviour is identical.

Decomposition:
- Shared package ram32_master_pkg:
  - opcode constants OP_WRITE/OP_READ/OP_FILL/OP_COPY.
  - state encoding constants.
  - ADDR_W/DATA_W defaults.
  - MAX_LEN=32.
- One natural sub-module: ram32_addr_counter, a wrapping ADDR_W counter with load/inc. It is instantiated twice (src/target and dst).

Test Plan:
- WRITE addr=5 data=0xBEEF → mem_write high exactly 1 cycle with mem_addr=5, mem_wdata=0xBEEF; done 2 cycles after accept; READ addr=5 → rsp_data=0xBEEF.
- READ addr=7 with rsp_ready held 0 for 4 cycles → rsp_valid stays 1, rsp_data stable, cmd_ready=0; rsp_ready=1 → done next cycle, cmd_ready=1 after.
- FILL addr=30 len=4 data=0x00A5 → writes at 30,31,0,1 on consecutive cycles; address 2 untouched (read back old value).
- COPY src=0 dst=16 len=3 after WRITEs 0x1111/0x2222/0x3333 to 0..2 → 6 memory cycles; READ 16..18 returns same values.
- FILL len=0 → done without any mem_write; rst_n pulsed low mid-FILL len=32 → mem_write drops immediately, all outputs at reset values, next command accepted normally.
- With RAM32_MASTER_CHECKSUM_EN: FILL len=3 data=0x8000 → wsum=0x8000 (wraps); WRITE 0x0001 → wsum=0x0001.
